// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator for game timing.
// A global IDLE/RUN/PAUSED FSM gates per-channel divide-by-N counters; channel 0 drives a frame count.
module game_tick_gen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 1000000,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               pause_i,
    input  logic [NUM_CH-1:0]  div_load_i,
    input  logic [CNT_W-1:0]   div_value_i,
    input  logic [NUM_CH-1:0]  slow_i,
    output logic [NUM_CH-1:0]  tick_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               running_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;

    localparam logic [CNT_W-1:0]   DefDiv  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0]   CntOne  = CNT_W'(1);
    localparam logic [FRAME_W-1:0] FrameOne = FRAME_W'(1);

    logic rst_sync1_q, rst_sync2_q;
    logic rst_int_n;

    logic [1:0]         state_q, state_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [CNT_W-1:0]   div_q [NUM_CH];
    logic [CNT_W-1:0]   div_d [NUM_CH];
    logic [NUM_CH-1:0]  phase_q, phase_d;
    logic [NUM_CH-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               count_en;

    // Assertion is asynchronous; release is delayed two edges so it never lands mid-edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync1_q <= 1'b0;
            rst_sync2_q <= 1'b0;
        end else begin
            rst_sync1_q <= 1'b1;
            rst_sync2_q <= rst_sync1_q;
        end
    end

    assign rst_int_n = rst_sync2_q;

    // Every enabled state resolves by pause alone, so the FSM reduces to one mux.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StRun, StPaused: state_d = pause_i ? StPaused : StRun;
                default:                 state_d = StIdle;
            endcase
        end
    end

    // Counting only happens on edges that start and end in RUN.
    assign count_en  = (state_q == StRun) && (state_d == StRun);
    assign running_d = (state_d == StRun);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            cnt_d[i]   = cnt_q[i];
            phase_d[i] = phase_q[i];
            tick_d[i]  = 1'b0;
            if (div_load_i[i]) begin
                div_d[i]   = div_value_i;
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end else if (state_d == StIdle) begin
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end else if (count_en) begin
                // Divisor 0 and 1 both terminate every cycle.
                if ((div_q[i] == '0) || (cnt_q[i] == div_q[i] - CntOne)) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = ~phase_q[i];
                    tick_d[i]  = ~slow_i[i] | phase_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    always_comb begin
        frame_d = frame_q;
        if (state_d == StIdle) begin
            frame_d = '0;
        end else if (tick_d[0]) begin
            frame_d = frame_q + FrameOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
            phase_q   <= '0;
            tick_q    <= '0;
            frame_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DefDiv;
            end
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            phase_q   <= phase_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end

    assign tick_o      = tick_q;
    assign frame_cnt_o = frame_q;
    assign running_o   = running_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Randomised self-checking bench for game_tick_gen against an edge-count reference model.
module tb_game_tick_gen;

    localparam int unsigned NC   = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 6;
    localparam int unsigned FW   = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          enable;
    logic          pause;
    logic [NC-1:0] div_load;
    logic [CW-1:0] div_value;
    logic [NC-1:0] slow;
    logic [NC-1:0] tick_o;
    logic [FW-1:0] frame_cnt_o;
    logic          running_o;

    game_tick_gen #(
        .NUM_CH     (NC),
        .CNT_W      (CW),
        .DEFAULT_DIV(DDIV),
        .FRAME_W    (FW)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .enable_i   (enable),
        .pause_i    (pause),
        .div_load_i (div_load),
        .div_value_i(div_value),
        .slow_i     (slow),
        .tick_o     (tick_o),
        .frame_cnt_o(frame_cnt_o),
        .running_o  (running_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0=idle 1=run 2=paused; edges counted since each channel was last cleared.
    int            m_state;
    int            m_edges [NC];
    int            m_div   [NC];
    int            m_frame;
    logic [NC-1:0] m_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_frame = 0;
        m_tick  = '0;
        for (int i = 0; i < NC; i++) begin
            m_edges[i] = 0;
            m_div[i]   = DDIV;
        end
    endtask

    task automatic cycle();
        int  nxt;
        int  deff;
        bit  counting;
        nxt      = !enable ? 0 : (pause ? 2 : 1);
        counting = (m_state == 1) && (nxt == 1);
        m_tick   = '0;
        for (int i = 0; i < NC; i++) begin
            deff = (m_div[i] == 0) ? 1 : m_div[i];
            if (div_load[i]) begin
                m_div[i]   = int'(div_value);
                m_edges[i] = 0;
            end else if (nxt == 0) begin
                m_edges[i] = 0;
            end else if (counting) begin
                m_edges[i]++;
                // k-th terminal count; in slow mode only every second one ticks.
                if (m_edges[i] % deff == 0)
                    m_tick[i] = !slow[i] || ((m_edges[i] / deff) % 2 == 0);
            end
        end
        if (nxt == 0) m_frame = 0;
        else if (m_tick[0]) m_frame = (m_frame + 1) % (1 << FW);
        m_state = nxt;
        @(posedge clk_i);
        #1;
        check_eq("tick", 32'(tick_o), 32'(m_tick));
        check_eq("frame_cnt", 32'(frame_cnt_o), 32'(m_frame));
        check_eq("running", 32'(running_o), 32'(m_state == 1));
    endtask

    task automatic load(input int ch, input int val);
        div_load     = '0;
        div_load[ch] = 1'b1;
        div_value    = CW'(val);
        cycle();
        div_load = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_tick"}, 32'(tick_o), 32'd0);
        check_eq({tag, "_frame"}, 32'(frame_cnt_o), 32'd0);
        check_eq({tag, "_running"}, 32'(running_o), 32'd0);
    endtask

    initial begin
        bit found;
        rst_ni    = 1'b1;
        enable    = 1'b0;
        pause     = 1'b0;
        div_load  = '0;
        div_value = '0;
        slow      = '0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("por");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) cycle();

        // ch0 /4, ch1 /3 slow, ch2 /0 (every cycle), ch3 /7; loaded while idle.
        load(0, 4);
        load(1, 3);
        load(2, 0);
        load(3, 7);
        slow   = 4'b0010;
        enable = 1'b1;
        repeat (30) cycle();

        // ch0 /5, pause with the counter at 2 for 7 cycles, then resume.
        load(0, 5);
        repeat (2) cycle();
        pause = 1'b1;
        repeat (7) cycle();
        pause = 1'b0;
        repeat (12) cycle();

        // Load coincident with a ch0 terminal count.
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (m_state == 1 && (m_edges[0] + 1) % m_div[0] == 0) found = 1'b1;
            else cycle();
        end
        check_eq("tc_align", 32'(found), 32'd1);
        load(0, 5);
        repeat (10) cycle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 99) < 96);
            pause     = ($urandom_range(0, 99) < 10);
            div_value = CW'($urandom_range(0, 9));
            for (int i = 0; i < NC; i++) begin
                div_load[i] = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 99) < 5) slow[i] = ~slow[i];
            end
            cycle();
        end
        div_load = '0;
        pause    = 1'b0;
        enable   = 1'b1;

        // Frame counter wrap with ch0 /1, then drop enable mid-run.
        slow = '0;
        load(0, 1);
        repeat (40) cycle();
        enable = 1'b0;
        cycle();
        check_zero_outputs("disable");

        // Asynchronous reset mid-count with ch0 /8.
        enable = 1'b1;
        repeat (2) cycle();
        load(0, 8);
        repeat (3) cycle();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("async_rst");
        enable = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) cycle();
        enable = 1'b1;
        repeat (3 * DDIV + 4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
